// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one SW-bit slice per stage, carry
// registered between slices, valid/ready on both ends with a global stall.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0]            vld_q, vld_d, v_i;
  logic [STAGES-1:0]            c_q, c_d, c_i;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, a_i;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d, b_i;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d, s_i;
  logic [STAGES-1:0][SW:0]      t;
  logic                         ovf_q, ovf_d;
  logic                         advance;

  assign out_valid = vld_q[STAGES-1] && !rst;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !rst;

  assign sum  = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf  = ovf_q;

  // Stage 0 takes the prepared operands; later stages take the previous register.
  for (genvar g = 0; g < STAGES; g++) begin : g_in
    if (g == 0) begin : g_first
      assign a_i[g] = a;
      assign b_i[g] = sub ? ~b : b;
      assign c_i[g] = sub | cin;
      assign s_i[g] = '0;
      assign v_i[g] = in_valid && in_ready;
    end else begin : g_rest
      assign a_i[g] = a_q[g-1];
      assign b_i[g] = b_q[g-1];
      assign c_i[g] = c_q[g-1];
      assign s_i[g] = s_q[g-1];
      assign v_i[g] = vld_q[g-1];
    end
  end

  always_comb begin
    ovf_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      t[k] = {1'b0, a_i[k][k*SW +: SW]} + {1'b0, b_i[k][k*SW +: SW]}
           + {{SW{1'b0}}, c_i[k]};
      a_d[k]   = a_i[k];
      b_d[k]   = b_i[k];
      s_d[k]   = s_i[k];
      s_d[k][k*SW +: SW] = t[k][SW-1:0];
      c_d[k]   = t[k][SW];
      vld_d[k] = v_i[k];
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      if (k == STAGES-1)
        ovf_d = a_i[k][WIDTH-1] ^ b_i[k][WIDTH-1] ^ t[k][SW-1] ^ t[k][SW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  // Final-stage operand copies are fully consumed and have no reader.
  logic unused_ok;
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: table vectors, streaming, backpressure and
// mid-flight reset, checked against a scoreboard of expected results.
module tb_pipe_adder;
  localparam int W  = 16;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co, ov;
    int           t;
    bit           lat;
  } exp_t;

  exp_t sbq[$];
  vec_t cur;
  bit   cur_lat;
  bit   acc;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic vec_t vv(input logic [W-1:0] a_, b_, input logic ci, sb,
                              input logic [W-1:0] s_, input logic co_, ov_);
    vec_t v;
    v.a = a_; v.b = b_; v.cin = ci; v.sub = sb; v.s = s_; v.co = co_; v.ov = ov_;
    return v;
  endfunction

  // Reference: plain wide addition, signed overflow by the sign rule.
  function automatic vec_t mk(input logic [W-1:0] a_, b_, input logic ci, sb);
    logic [W-1:0] be;
    logic [W:0]   tt;
    be = sb ? ~b_ : b_;
    tt = {1'b0, a_} + {1'b0, be} + (W+1)'(sb | ci);
    return vv(a_, b_, ci, sb, tt[W-1:0], tt[W],
              (a_[W-1] == be[W-1]) && (tt[W-1] != a_[W-1]));
  endfunction

  task automatic drive(input vec_t v, input bit lat);
    cur = v; cur_lat = lat;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1;
  endtask

  // One clock: observe handshakes at the falling edge, return 1 after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got sum %0h with no pending operation (cycle %0d)", sum, cyc);
      end else begin
        e = sbq.pop_front();
        chk("sum",  32'(sum),  32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf",  32'(ovf),  32'(e.ov));
        if (e.lat) chk("latency", 32'(cyc - e.t), 32'(ST));
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e.s = cur.s; e.co = cur.co; e.ov = cur.ov; e.t = cyc; e.lat = cur_lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string nm, input int bound);
    for (int k = 0; k < bound && sbq.size() != 0; k++) tick();
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d results pending, required 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic [W-1:0] held;
    tbl[0] = vv(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    tbl[1] = vv(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    tbl[2] = vv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    tbl[3] = vv(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tbl[4] = vv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tbl[5] = vv(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    tbl[6] = vv(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    tbl[7] = vv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tbl[8] = vv(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    cur = tbl[0]; cur_lat = 1'b0; acc = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready),  32'd1);
    chk("post_rst_valid",    32'(out_valid), 32'd0);
    chk("post_rst_sum",      32'(sum),       32'd0);
    chk("post_rst_cout",     32'(cout),      32'd0);
    chk("post_rst_ovf",      32'(ovf),       32'd0);

    // Table vectors, one at a time
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i], 1'b1);
      tick();
      chk("vec_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
      drain("vec", 12);
    end

    // Back-to-back stream of 8 random operands
    for (int i = 0; i < 8; i++) begin
      drive(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), 1'b1);
      tick();
      chk("stream_accept", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    drain("stream", 12);

    // Backpressure: fill with out_ready low, then hold 5 cycles
    out_ready = 1'b0;
    drive(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), 1'b0);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      tick();
      if (acc) drive(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), 1'b0);
    end
    chk("bp_full", 32'(out_valid), 32'd1);
    chk("bp_depth", 32'(sbq.size()), 32'(ST));
    held = sum;
    repeat (5) begin
      tick();
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum_hold",  32'(sum),       32'(held));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_take_and_accept", 32'(acc), 32'd1);
      drive(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), 1'b0);
    end
    in_valid = 1'b0;
    drain("bp", 16);
    repeat (2) tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Reset with 3 operations in flight
    for (int i = 0; i < 3; i++) begin
      drive(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk);
    #1;
    sbq.delete();
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(in_ready),  32'd1);
    chk("midrst_release_valid", 32'(out_valid), 32'd0);
    repeat (6) tick();
    drive(tbl[0], 1'b1);
    tick();
    in_valid = 1'b0;
    drain("midrst", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
